regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between CPU writeback and N external injectors, such as the button-score updater that writes register 30. CPU writeback always wins and passes through in the same cycle. External writes are buffered one per requester and injected round-robin on cycles where the CPU does not write. The block sits between the processor's writeback outputs and the regfile write inputs in the top level.

---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_rr_pick.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the regfile write-port arbiter.
// Slot layout and register indices used by top and picker.
package regfile_write_arbiter_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int ID_W      = 3;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [RF_ADDR_W-1:0] REG_SCORE = 5'd30;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } slot_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin first-set finder: scans mask upward from ptr with wrap.
// Purely combinational; index is 0 when nothing is found.
module rr_pick
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && mask[i] &&
            ((int'(ptr) + k) % N) == i) begin
          found = 1'b1;
          index = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between CPU writeback and N buffered
// external writers; CPU always wins, externals inject round-robin.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [RF_ADDR_W-1:0]       cpu_rd,
  input  logic [RF_DATA_W-1:0]       cpu_wdata,
  input  logic [N_REQ-1:0]           ext_valid,
  input  logic [RF_ADDR_W*N_REQ-1:0] ext_rd,
  input  logic [RF_DATA_W*N_REQ-1:0] ext_wdata,
  output logic [N_REQ-1:0]           ext_ready,
  output logic                       rf_we,
  output logic [RF_ADDR_W-1:0]       rf_rd,
  output logic [RF_DATA_W-1:0]       rf_wdata,
  output logic                       inj_valid,
  output logic [ID_W-1:0]            inj_id,
  output logic                       starve
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  slot_t            slot_q [N_REQ];
  logic [N_REQ-1:0] slot_valid;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             inject;
  slot_t            pick_slot;

  for (genvar g = 0; g < N_REQ; g++) begin : g_valid
    assign slot_valid[g] = slot_q[g].valid;
  end

  assign ext_ready = ~slot_valid & {N_REQ{~reset}};

  rr_pick #(.N(N_REQ)) u_pick (
    .mask  (slot_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign inject = !cpu_we && pick_found;

  always_comb begin
    pick_slot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) pick_slot = slot_q[i];
    end
  end

  always_comb begin
    rf_we     = 1'b0;
    rf_rd     = REG_ZERO;
    rf_wdata  = '0;
    inj_valid = 1'b0;
    inj_id    = '0;
    unique case (1'b1)
      cpu_we: begin
        rf_we    = 1'b1;
        rf_rd    = cpu_rd;
        rf_wdata = cpu_wdata;
      end
      inject: begin
        rf_we     = 1'b1;
        rf_rd     = pick_slot.rd;
        rf_wdata  = pick_slot.data;
        inj_valid = 1'b1;
        inj_id    = pick_idx;
      end
      default: ;
    endcase
  end

  // A slot is never both empty (capturable) and granted, so the
  // capture and clear paths below cannot collide.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        slot_q[g] <= '0;
      end else if (inject && pick_idx == ID_W'(g)) begin
        slot_q[g].valid <= 1'b0;
      end else if (ext_valid[g] && ext_ready[g]) begin
        slot_q[g].valid <= ext_rd[RF_ADDR_W*g +: RF_ADDR_W] != REG_ZERO;
        slot_q[g].rd    <= ext_rd[RF_ADDR_W*g +: RF_ADDR_W];
        slot_q[g].data  <= ext_wdata[RF_DATA_W*g +: RF_DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (inject) begin
      rr_ptr <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (inject || !(|slot_valid)) begin
      starve_cnt <= '0;
    end else if (cpu_we && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve = starve_cnt == LIMIT;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected rf writes, a negedge
// monitor pops and compares every rf_we cycle.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_wdata;
  logic [1:0]  ext_valid;
  logic [9:0]  ext_rd;
  logic [63:0] ext_wdata;
  logic [1:0]  ext_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        inj_valid;
  logic [2:0]  inj_id;
  logic        starve;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        inj;
    logic [2:0]  id;
  } exp_t;

  exp_t q[$];

  regfile_write_arbiter #(.N_REQ(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_rd    (cpu_rd),
    .cpu_wdata (cpu_wdata),
    .ext_valid (ext_valid),
    .ext_rd    (ext_rd),
    .ext_wdata (ext_wdata),
    .ext_ready (ext_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .inj_valid (inj_valid),
    .inj_id    (inj_id),
    .starve    (starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d,
                      input logic inj, input logic [2:0] id);
    exp_t e;
    e.rd = rd; e.data = d; e.inj = inj; e.id = id;
    q.push_back(e);
  endtask

  task automatic push_cpu(input logic [4:0] rd, input logic [31:0] d);
    cpu_we = 1'b1; cpu_rd = rd; cpu_wdata = d;
    push(rd, d, 1'b0, 3'd0);
  endtask

  task automatic set_ext(input int i, input logic v, input logic [4:0] rd,
                         input logic [31:0] d);
    ext_valid[i]        = v;
    ext_rd[5*i +: 5]    = rd;
    ext_wdata[32*i +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL rf_unexpected actual=rd%0d/%0h inj=%0b id=%0d required=no_write",
                 rf_rd, rf_wdata, inj_valid, inj_id);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rf_rd !== e.rd || rf_wdata !== e.data ||
            inj_valid !== e.inj || inj_id !== e.id) begin
          failures++;
          $display("FAIL rf_write actual=rd%0d/%0h inj=%0b id=%0d required=rd%0d/%0h inj=%0b id=%0d",
                   rf_rd, rf_wdata, inj_valid, inj_id,
                   e.rd, e.data, e.inj, e.id);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cpu_we = 1'b0; cpu_rd = '0; cpu_wdata = '0;
    ext_valid = '0; ext_rd = '0; ext_wdata = '0;
    tick();
    tick();
    chk("reset_ready", 64'(ext_ready), 64'h0);
    chk("reset_starve", 64'(starve), 64'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 64'(ext_ready), 64'h3);

    // Basic injection latency
    set_ext(0, 1'b1, 5'd30, 32'd5);
    push(5'd30, 32'd5, 1'b1, 3'd0);
    tick();
    ext_valid = '0;
    chk("t1_ready_busy", 64'(ext_ready[0]), 64'h0);
    tick();
    chk("t1_ready_free", 64'(ext_ready[0]), 64'h1);

    // CPU blocks a pending slot targeting the same register
    push_cpu(5'd3, 32'hAA);
    set_ext(0, 1'b1, 5'd3, 32'h55);
    tick();
    ext_valid = '0;
    for (int k = 0; k < 4; k++) begin
      push_cpu(5'd3, 32'hAA);
      chk("t2_ready_blocked", 64'(ext_ready[0]), 64'h0);
      tick();
    end
    cpu_we = 1'b0;
    push(5'd3, 32'h55, 1'b1, 3'd0);
    tick();
    chk("t2_ready_free", 64'(ext_ready[0]), 64'h1);

    // rr_ptr is 1 here: both pending -> 1 first, then 0
    set_ext(0, 1'b1, 5'd12, 32'h120);
    set_ext(1, 1'b1, 5'd13, 32'h130);
    push(5'd13, 32'h130, 1'b1, 3'd1);
    push(5'd12, 32'h120, 1'b1, 3'd0);
    tick();
    ext_valid = '0;
    tick();
    tick();
    chk("t3_ready_empty", 64'(ext_ready), 64'h3);

    // Inject slot1 alone so rr_ptr wraps to 0
    set_ext(1, 1'b1, 5'd5, 32'h11);
    push(5'd5, 32'h11, 1'b1, 3'd1);
    tick();
    ext_valid = '0;
    tick();
    for (int r = 0; r < 2; r++) begin
      set_ext(0, 1'b1, 5'(7 + 2*r), 32'h100 + 32'(r));
      set_ext(1, 1'b1, 5'(8 + 2*r), 32'h200 + 32'(r));
      push(5'(7 + 2*r), 32'h100 + 32'(r), 1'b1, 3'd0);
      push(5'(8 + 2*r), 32'h200 + 32'(r), 1'b1, 3'd1);
      tick();
      ext_valid = '0;
      chk("t3_both_busy", 64'(ext_ready), 64'h0);
      tick();
      tick();
    end
    chk("t3_refill_free", 64'(ext_ready), 64'h3);

    // r0 write is accepted and dropped
    set_ext(1, 1'b1, 5'd0, 32'd7);
    tick();
    ext_valid = '0;
    chk("t4_r0_ready", 64'(ext_ready[1]), 64'h1);
    tick();
    tick();

    // Starvation with limit 4
    push_cpu(5'd1, 32'h0);
    set_ext(0, 1'b1, 5'd30, 32'd9);
    chk("t5_starve_c0", 64'(starve), 64'h0);
    tick();
    ext_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      push_cpu(5'd1, 32'(k));
      chk("t5_starve_blocked", 64'(starve), 64'(k >= 5));
      tick();
    end
    cpu_we = 1'b0;
    push(5'd30, 32'd9, 1'b1, 3'd0);
    chk("t5_starve_inject", 64'(starve), 64'h1);
    tick();
    chk("t5_starve_clear", 64'(starve), 64'h0);

    // Reset with both slots full (rr_ptr is 1 beforehand)
    push_cpu(5'd2, 32'hBEEF);
    set_ext(0, 1'b1, 5'd20, 32'h20);
    set_ext(1, 1'b1, 5'd21, 32'h21);
    tick();
    ext_valid = '0;
    cpu_we = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_reset_ready", 64'(ext_ready), 64'h0);
    tick();
    chk("t6_reset_ready_hold", 64'(ext_ready), 64'h0);
    chk("t6_reset_inj", 64'(inj_valid), 64'h0);
    reset = 1'b0;
    #1;
    chk("t6_release_ready", 64'(ext_ready), 64'h3);
    set_ext(0, 1'b1, 5'd22, 32'h22);
    set_ext(1, 1'b1, 5'd23, 32'h23);
    push(5'd22, 32'h22, 1'b1, 3'd0);
    push(5'd23, 32'h23, 1'b1, 3'd1);
    tick();
    ext_valid = '0;
    tick();
    tick();
    tick();
    chk("scoreboard_drained", 64'(q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
